fifo_syn: RTL and testbench

Single-clock synchronous FIFO, 16 entries x 8 bits by default. It buffers a byte stream between a producer and a consumer that share one clock domain. It provides registered read data and full/empty status flags. Writes into a full FIFO and reads from an empty FIFO are ignored.

---
 rtl/fifo_syn_pkg.sv | 13 +
 rtl/fifo_syn_mem.sv | 42 ++++
 rtl/fifo_syn.sv | 85 ++++++++
 tb/tb_fifo_syn.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_syn_pkg.sv
// Shared sizing defaults for the synchronous byte FIFO.
package fifo_syn_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    // Number of storage entries addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage : fifo_syn_pkg

// File: rtl/fifo_syn_mem.sv
// Simple dual-port RAM: synchronous write port, registered read port.
// Only the read-data register is reset; the storage array keeps its contents.
module fifo_syn_mem
    import fifo_syn_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write; no reset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read: output updates only on an accepted read, else holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : fifo_syn_mem

// File: rtl/fifo_syn.sv
// Single-clock synchronous FIFO with registered read data and
// full/empty flags derived from an occupancy counter.
module fifo_syn
    import fifo_syn_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] Din,
    output logic [DATA_WIDTH-1:0] Dout,
    output logic                  full,
    output logic                  empty
);

    localparam int                  DEPTH      = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_en;
    logic                  rd_en;

    // Flags come straight from the registered count, so they are glitch-free
    // and change on the same edge as the operation that moves the count.
    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);

    // Requests are qualified by pre-edge flags: a write on full or a read
    // on empty is silently dropped (no fall-through when empty).
    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards any buffered data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    fifo_syn_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wptr_q),
        .wdata (Din),
        .re    (rd_en),
        .raddr (rptr_q),
        .rdata (Dout)
    );

endmodule : fifo_syn

// File: tb/tb_fifo_syn.sv
// Bench for fifo_syn: directed plan plus randomized traffic, compared
// every cycle against a queue-based model of the FIFO.
module tb_fifo_syn;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic [DW-1:0] Din = '0;
    logic [DW-1:0] Dout;
    logic          full;
    logic          empty;

    int n_total = 0;
    int n_pass  = 0;

    fifo_syn dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .rd    (rd),
        .Din   (Din),
        .Dout  (Dout),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of stored bytes plus the last byte read.
    logic [DW-1:0] q[$];
    logic [DW-1:0] dout_m = '0;
    bit            m_we;
    bit            m_re;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            dout_m = '0;
        end else begin
            m_we = wr && (q.size() < DEPTH);
            m_re = rd && (q.size() > 0);
            if (m_re) dout_m = q.pop_front();
            if (m_we) q.push_back(Din);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        check("cmp_Dout", int'(Dout), int'(dout_m));
        check("cmp_full", int'(full), int'(q.size() == DEPTH));
        check("cmp_empty", int'(empty), int'(q.size() == 0));
    end

    // One clock: drive inputs, let the edge happen, settle 1ns past it.
    task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
        wr  = w;
        rd  = r;
        Din = d;
        @(posedge clk);
        #1;
    endtask

    int exp_v;
    int pw;

    initial begin
        // Reset
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_Dout", int'(Dout), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        rst = 1'b0;

        // Fill 0..15
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, DW'(i));
            if (i == 0)  check("fill_empty_falls", int'(empty), 0);
            if (i == 14) check("fill_not_full_15", int'(full), 0);
        end
        check("fill_full", int'(full), 1);
        check("fill_empty", int'(empty), 0);

        // Overflow write of 99 is dropped
        cyc(1'b1, 1'b0, 8'd99);
        check("ovf_full", int'(full), 1);
        check("ovf_model_size", q.size(), 16);

        // Drain: expect 0..15, never 99
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, 8'd0);
            check("drain_Dout", int'(Dout), i);
        end
        check("drain_empty", int'(empty), 1);

        // Underflow: Dout holds 15
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'd0);
            check("unf_Dout", int'(Dout), 15);
            check("unf_empty", int'(empty), 1);
        end

        // Preload 8, then 20 simultaneous cycles across the pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(100 + i));
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b1, DW'(200 + k));
            exp_v = (k < 8) ? (100 + k) : (200 + k - 8);
            check("simul_Dout", int'(Dout), exp_v);
            check("simul_full", int'(full), 0);
            check("simul_empty", int'(empty), 0);
        end
        check("simul_model_size", q.size(), 8);

        // Top up to full (holds 212..219 then 50..57)
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(50 + i));
        check("topup_full", int'(full), 1);
        cyc(1'b1, 1'b1, 8'd77);
        check("full_rw_Dout", int'(Dout), 212);
        check("full_rw_full", int'(full), 0);
        cyc(1'b1, 1'b0, 8'd78);
        check("refill_full", int'(full), 1);

        // Mid-stream reset with 5 entries held and Dout nonzero
        cyc(1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, DW'(i));
        cyc(1'b0, 1'b1, 8'd0);
        check("pre_rst_Dout", int'(Dout), 1);
        check("pre_rst_size", q.size(), 5);
        rst = 1'b1;
        #1;
        check("async_rst_Dout", int'(Dout), 0);
        check("async_rst_empty", int'(empty), 1);
        check("async_rst_full", int'(full), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 8'hA5);
        check("post_rst_empty", int'(empty), 0);
        cyc(1'b0, 1'b1, 8'd0);
        check("post_rst_Dout", int'(Dout), 8'hA5);
        check("post_rst_empty2", int'(empty), 1);

        // Randomized traffic with shifting write/read bias
        for (int n = 0; n < 3000; n++) begin
            case ((n / 250) % 3)
                0:       pw = 80;
                1:       pw = 50;
                default: pw = 20;
            endcase
            cyc($urandom_range(0, 99) < pw,
                $urandom_range(0, 99) < (100 - pw),
                DW'($urandom));
        end

        wr = 1'b0;
        rd = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fifo_syn
